// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with an Avalon-MM register slave and an Avalon-ST pixel sink.
// Latency: every coe_* output is registered, so it shows the h/v position of the previous clock.
//          A beat accepted in cycle t is on the DAC pins in cycle t+1. readdata arrives one clock after read.
// Backpressure: asi_pix_ready is high only in the active region while enabled without test pattern.
//               The raster never stalls; when the source has no pixel, the FILL colour is shown and UNDERRUN is flagged.
// Ports: csi_vga_clock_clk / rsi_vga_reset_reset_n    pixel clock and async active-low reset
//        avs_cmd_*                                      register slave (CTRL, STATUS, HPOS, VPOS, FRAMECNT, FILL)
//        asi_pix_*                                      {R,G,B} pixel stream; sop marks pixel (0,0)
//        coe_vga_*                                      DAC colour, blank_n, sync_n, hsync, vsync
module vga_timing_ctrl #(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 12,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                   csi_vga_clock_clk,
  input  logic                   rsi_vga_reset_reset_n,
  input  logic [2:0]             avs_cmd_address,
  input  logic                   avs_cmd_read,
  input  logic                   avs_cmd_write,
  input  logic [15:0]            avs_cmd_writedata,
  output logic [15:0]            avs_cmd_readdata,
  output logic                   avs_cmd_waitrequest,
  input  logic [3*COLOR_W-1:0]   asi_pix_data,
  input  logic                   asi_pix_valid,
  input  logic                   asi_pix_startofpacket,
  output logic                   asi_pix_ready,
  output logic [COLOR_W-1:0]     coe_vga_red,
  output logic [COLOR_W-1:0]     coe_vga_green,
  output logic [COLOR_W-1:0]     coe_vga_blue,
  output logic                   coe_vga_blank_n,
  output logic                   coe_vga_sync_n,
  output logic                   coe_vga_hsync,
  output logic                   coe_vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_HPOS     = 3'd2;
  localparam logic [2:0] A_VPOS     = 3'd3;
  localparam logic [2:0] A_FRAMECNT = 3'd4;
  localparam logic [2:0] A_FILL     = 3'd5;

  // RGB565 field widening by repeating the field from its MSB down.
  function automatic logic [COLOR_W-1:0] rep5(input logic [4:0] c);
    logic [5*COLOR_W-1:0] w;
    w = {COLOR_W{c}};
    return w[5*COLOR_W-1 -: COLOR_W];
  endfunction

  function automatic logic [COLOR_W-1:0] rep6(input logic [5:0] c);
    logic [6*COLOR_W-1:0] w;
    w = {COLOR_W{c}};
    return w[6*COLOR_W-1 -: COLOR_W];
  endfunction

  // Raster counters
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             line_end, frame_end, active, at_origin;

  // Registers
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] fill_q, fill_d;
  logic [15:0] framecnt_q, framecnt_d;
  logic        eff_en_q, eff_en_d, eff_tpat_q, eff_tpat_d;
  logic        underrun_q, underrun_d, syncerr_q, syncerr_d;
  logic [15:0] readdata_q, readdata_d, rd_val;

  // Registered DAC outputs
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               blank_n_q, blank_n_d, hsync_q, hsync_d, vsync_q, vsync_d;

  logic pix_ready, consume, underrun_evt, syncerr_evt;
  logic wr_ctrl, wr_fill;
  logic [1:0] w1c;

  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);
  assign active    = (h_q < H_ACT) && (v_q < V_ACT);
  assign at_origin = (h_q == '0) && (v_q == '0);

  assign pix_ready    = active && eff_en_q && !eff_tpat_q;
  assign consume      = pix_ready && asi_pix_valid;
  assign underrun_evt = pix_ready && !asi_pix_valid;
  // sop must mark exactly the beat taken at (0,0); anything else is a framing error.
  assign syncerr_evt  = consume && (at_origin ? !asi_pix_startofpacket : asi_pix_startofpacket);

  assign wr_ctrl = avs_cmd_write && (avs_cmd_address == A_CTRL);
  assign wr_fill = avs_cmd_write && (avs_cmd_address == A_FILL);
  assign w1c     = (avs_cmd_write && (avs_cmd_address == A_STATUS)) ? avs_cmd_writedata[2:1] : 2'b00;

  always_comb begin
    h_d        = line_end ? '0 : h_q + 1'b1;
    v_d        = v_q;
    if (line_end) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    framecnt_d = frame_end ? framecnt_q + 16'd1 : framecnt_q;
    // Mode only changes across the frame boundary so a frame is never split between modes.
    eff_en_d   = frame_end ? ctrl_q[0] : eff_en_q;
    eff_tpat_d = frame_end ? ctrl_q[1] : eff_tpat_q;
    ctrl_d     = wr_ctrl ? avs_cmd_writedata[1:0] : ctrl_q;
    fill_d     = wr_fill ? avs_cmd_writedata : fill_q;
    // Set term is OR-ed after the clear so a same-cycle event survives the W1C.
    underrun_d = (underrun_q & ~w1c[0]) | underrun_evt;
    syncerr_d  = (syncerr_q  & ~w1c[1]) | syncerr_evt;
  end

  always_comb begin
    rd_val = '0;
    case (avs_cmd_address)
      A_CTRL:     rd_val = {14'd0, ctrl_q};
      A_STATUS:   rd_val = {13'd0, syncerr_q, underrun_q, (v_q >= V_ACT)};
      A_HPOS:     rd_val = 16'(h_q);
      A_VPOS:     rd_val = 16'(v_q);
      A_FRAMECNT: rd_val = framecnt_q;
      A_FILL:     rd_val = fill_q;
      default:    rd_val = '0;
    endcase
    readdata_d = avs_cmd_read ? rd_val : readdata_q;
  end

  always_comb begin
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    blank_n_d = 1'b0;
    if (active && eff_en_q) begin
      blank_n_d = 1'b1;
      if (eff_tpat_q) begin
        red_d   = h_q[COLOR_W-1:0];
        green_d = v_q[COLOR_W-1:0];
        blue_d  = h_q[COLOR_W-1:0] ^ v_q[COLOR_W-1:0];
      end else if (asi_pix_valid) begin
        {red_d, green_d, blue_d} = asi_pix_data;
      end else begin
        red_d   = rep5(fill_q[15:11]);
        green_d = rep6(fill_q[10:5]);
        blue_d  = rep5(fill_q[4:0]);
      end
    end
    hsync_d = ((h_q >= H_SYNC_S) && (h_q < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_q >= V_SYNC_S) && (v_q < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge csi_vga_clock_clk or negedge rsi_vga_reset_reset_n) begin
    if (!rsi_vga_reset_reset_n) begin
      h_q        <= '0;
      v_q        <= '0;
      framecnt_q <= '0;
      ctrl_q     <= '0;
      fill_q     <= '0;
      eff_en_q   <= 1'b0;
      eff_tpat_q <= 1'b0;
      underrun_q <= 1'b0;
      syncerr_q  <= 1'b0;
      readdata_q <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      blank_n_q  <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      framecnt_q <= framecnt_d;
      ctrl_q     <= ctrl_d;
      fill_q     <= fill_d;
      eff_en_q   <= eff_en_d;
      eff_tpat_q <= eff_tpat_d;
      underrun_q <= underrun_d;
      syncerr_q  <= syncerr_d;
      readdata_q <= readdata_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      blank_n_q  <= blank_n_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign asi_pix_ready       = pix_ready;
  assign avs_cmd_readdata    = readdata_q;
  assign avs_cmd_waitrequest = 1'b0;
  assign coe_vga_red         = red_q;
  assign coe_vga_green       = green_q;
  assign coe_vga_blue        = blue_q;
  assign coe_vga_blank_n     = blank_n_q;
  assign coe_vga_sync_n      = 1'b0;
  assign coe_vga_hsync       = hsync_q;
  assign coe_vga_vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed bench for vga_timing_ctrl on a reduced 24x12 raster.
// Latency: outputs are sampled on the falling edge; coe_* there reflect the previous cycle's position.
// Backpressure: the pixel source honours ready and can drop valid or flip sop at chosen positions.
module tb_vga_timing_ctrl;
  localparam int CW = 8;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 12
  localparam int FR = HT * VT;             // 288

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [15:0]   avs_writedata = '0;
  logic [15:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [3*CW-1:0] src_dat = '0;
  logic          src_vld = 1'b0, src_sop = 1'b0;
  logic          asi_pix_ready;
  logic [CW-1:0] red, green, blue;
  logic          blank_n, sync_n, hsync, vsync;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Source controls, written only by the main sequence
  logic drop_en = 1'b0, flip_en = 1'b0;
  int   drop_v = 0, drop_lo = 0, drop_hi = 0, flip_h = 0, flip_v = 0;
  int   beat = 0, frame_beats = 0;

  vga_timing_ctrl #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(12), .SYNC_POL(1'b0)
  ) dut (
    .csi_vga_clock_clk    (clk),
    .rsi_vga_reset_reset_n(rst_n),
    .avs_cmd_address      (avs_address),
    .avs_cmd_read         (avs_read),
    .avs_cmd_write        (avs_write),
    .avs_cmd_writedata    (avs_writedata),
    .avs_cmd_readdata     (avs_readdata),
    .avs_cmd_waitrequest  (avs_waitrequest),
    .asi_pix_data         (src_dat),
    .asi_pix_valid        (src_vld),
    .asi_pix_startofpacket(src_sop),
    .asi_pix_ready        (asi_pix_ready),
    .coe_vga_red          (red),
    .coe_vga_green        (green),
    .coe_vga_blue         (blue),
    .coe_vga_blank_n      (blank_n),
    .coe_vga_sync_n       (sync_n),
    .coe_vga_hsync        (hsync),
    .coe_vga_vsync        (vsync)
  );

  always #5 clk = ~clk;

  // Bench position reference: clocks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int pos_h(input int c);
    return c % HT;
  endfunction

  function automatic int pos_v(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic logic [23:0] mkdat(input int b);
    return 24'(b * 32'h0001_0307) ^ 24'h5A3C96;
  endfunction

  // Pixel source: new values are driven shortly after each rising edge.
  initial begin
    logic cons;
    logic cons_org;
    forever begin
      @(negedge clk);
      cons     = asi_pix_ready && src_vld;
      cons_org = (pos_h(cyc) == 0) && (pos_v(cyc) == 0);
      @(posedge clk);
      #2;
      if (cons) begin
        beat++;
        frame_beats = cons_org ? 1 : frame_beats + 1;
      end
      src_dat = mkdat(beat);
      src_vld = !(drop_en && pos_v(cyc) == drop_v && pos_h(cyc) >= drop_lo && pos_h(cyc) <= drop_hi);
      src_sop = ((pos_h(cyc) == 0) && (pos_v(cyc) == 0)) ^
                (flip_en && pos_h(cyc) == flip_h && pos_v(cyc) == flip_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: at cycle %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic bn;
    logic rdy;
  } tvec_t;

  initial begin
    tvec_t       tv[9];
    logic [15:0] rd;
    logic [23:0] cap;
    int          cnt;
    int          f;

    // Sync timing with EN = 0: hsync low for h in [18,21), vsync low for v in [7,9).
    tv[0] = '{0,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[1] = '{17, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[2] = '{18, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3] = '{20, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4] = '{21, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5] = '{23, 6, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6] = '{0,  7, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{19, 8, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8] = '{0,  9, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_blank_n", blank_n, 1'b0);
    chk("rst_sync_n", sync_n, 1'b0);
    chk("rst_rgb", {red, green, blue}, 24'h0);
    chk("rst_ready", asi_pix_ready, 1'b0);
    chk("rst_readdata", avs_readdata, 16'h0);
    chk("rst_waitreq", avs_waitrequest, 1'b0);
    rst_n = 1'b1;

    // Frame 0: timing table
    for (int i = 0; i < 9; i++) begin
      wait_cyc(tv[i].v * HT + tv[i].h);
      chk($sformatf("tab%0d_ready", i), asi_pix_ready, tv[i].rdy);
      step();
      chk($sformatf("tab%0d_hsync", i), hsync, tv[i].hs);
      chk($sformatf("tab%0d_vsync", i), vsync, tv[i].vs);
      chk($sformatf("tab%0d_blank_n", i), blank_n, tv[i].bn);
      chk($sformatf("tab%0d_rgb", i), {red, green, blue}, 24'h0);
    end

    // Frame 1: enable mid-frame; nothing happens until the next frame
    f = FR;
    wait_cyc(f + 2 * HT);
    reg_write(3'd0, 16'h0001);
    wait_cyc(f + 3 * HT + 5);
    chk("midframe_ready", asi_pix_ready, 1'b0);
    step();
    chk("midframe_blank_n", blank_n, 1'b0);

    // Frame 2: streaming
    f = 2 * FR;
    wait_cyc(f);
    chk("f2_origin_ready", asi_pix_ready, 1'b1);
    cap = src_dat;
    step();
    chk("f2_first_rgb", {red, green, blue}, cap);
    chk("f2_first_blank_n", blank_n, 1'b1);
    wait_cyc(f + 3 * HT);
    cnt = 0;
    for (int i = 0; i < HT; i++) begin
      if (asi_pix_ready) cnt++;
      step();
    end
    chk("f2_line_ready_cnt", cnt, HA);
    wait_cyc(f + 7 * HT);
    chk("f2_beats", frame_beats, HA * VA);
    reg_read(3'd1, rd);
    chk("f2_status", rd, 16'h0001);
    reg_read(3'd4, rd);
    chk("f2_framecnt", rd, 16'd2);
    reg_write(3'd5, 16'hF800);
    drop_v = 1; drop_lo = 10; drop_hi = 12; drop_en = 1'b1;

    // Frame 3: three-cycle underrun at (10..12, 1)
    f = 3 * FR;
    wait_cyc(f + HT + 10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("under%0d_ready", i), asi_pix_ready, 1'b1);
      step();
      chk($sformatf("under%0d_rgb", i), {red, green, blue}, 24'hFF0000);
      chk($sformatf("under%0d_blank_n", i), blank_n, 1'b1);
    end
    cap = src_dat;
    step();
    chk("after_under_rgb", {red, green, blue}, cap);
    wait_cyc(f + 2 * HT);
    reg_read(3'd1, rd);
    chk("under_status", rd, 16'h0002);
    reg_write(3'd1, 16'h0002);
    reg_read(3'd1, rd);
    chk("under_cleared", rd, 16'h0000);
    reg_read(3'd4, rd);
    chk("f3_framecnt", rd, 16'd3);
    drop_en = 1'b0;
    flip_h = 5; flip_v = 0; flip_en = 1'b1;

    // Frame 4: stray sop at (5,0); pixel still shown
    f = 4 * FR;
    wait_cyc(f + 5);
    cap = src_dat;
    step();
    chk("syncerr_pix_rgb", {red, green, blue}, cap);
    wait_cyc(f + HT);
    reg_read(3'd1, rd);
    chk("syncerr_sop_mid", rd, 16'h0004);
    reg_write(3'd1, 16'h0004);
    reg_read(3'd1, rd);
    chk("syncerr_cleared", rd, 16'h0000);
    flip_h = 0; flip_v = 0;

    // Frame 5: missing sop at (0,0); then W1C racing a new underrun
    f = 5 * FR;
    wait_cyc(f + HT);
    flip_en = 1'b0;
    reg_read(3'd1, rd);
    chk("syncerr_no_sop", rd, 16'h0004);
    drop_v = 2; drop_lo = 2; drop_hi = 2; drop_en = 1'b1;
    wait_cyc(f + 2 * HT + 2);
    reg_write(3'd1, 16'h0002);
    wait_cyc(f + 2 * HT + 8);
    reg_read(3'd1, rd);
    chk("w1c_vs_event", rd, 16'h0006);
    drop_en = 1'b0;
    reg_write(3'd0, 16'h0003);

    // Frame 6: test pattern
    f = 6 * FR;
    wait_cyc(f + 2 * HT + 5);
    chk("tpat_ready_a", asi_pix_ready, 1'b0);
    step();
    chk("tpat_rgb_a", {red, green, blue}, 24'h050207);
    chk("tpat_blank_a", blank_n, 1'b1);
    wait_cyc(f + 4 * HT + 13);
    chk("tpat_ready_b", asi_pix_ready, 1'b0);
    step();
    chk("tpat_rgb_b", {red, green, blue}, 24'h0D0409);

    // Asynchronous reset in the active region
    wait_cyc(f + 5 * HT + 10);
    chk("prereset_blank_n", blank_n, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("areset_blank_n", blank_n, 1'b0);
    chk("areset_rgb", {red, green, blue}, 24'h0);
    chk("areset_ready", asi_pix_ready, 1'b0);
    chk("areset_readdata", avs_readdata, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Counting restarts from (0,0); registers back to defaults
    wait_cyc(30);
    reg_read(3'd2, rd);
    chk("post_hpos", rd, 16'd6);
    repeat (3) step();
    chk("readdata_hold", avs_readdata, 16'd6);
    reg_read(3'd3, rd);
    chk("post_vpos", rd, 16'd1);
    reg_read(3'd0, rd);
    chk("post_ctrl", rd, 16'h0);
    reg_read(3'd5, rd);
    chk("post_fill", rd, 16'h0);
    reg_read(3'd4, rd);
    chk("post_framecnt", rd, 16'h0);
    reg_write(3'd7, 16'hFFFF);
    reg_read(3'd6, rd);
    chk("unmapped_read", rd, 16'h0);
    chk("post_ready", asi_pix_ready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
